// File: rtl/vi_rst_pulse_seq.sv
// vi_rst_pulse_seq
// Multi-channel reset stretcher and sequencer. Turns short control-register
// reset requests into stretched active-low reset pulses, one per channel, and
// releases all channels enabled in seq_mask in a fixed staggered order on a
// global request or on block reset.
//
// Ports:
//   clk          block clock
//   rst          synchronous active-high reset (also starts the power-on sequence)
//   ch_req       per-channel reset request, pulse or level
//   glb_req      global sequenced reset request
//   seq_mask     channels that take part in a global sequence
//   stretch_len  hold length in cycles (0 behaves as 1)
//   stagger_len  extra delay between successive releases in a global sequence
//   rst_out_n    stretched active-low reset per channel (registered)
//   busy         some channel is held in reset (registered)
//   seq_done     one-cycle pulse when a global sequence completes (registered)
module vi_rst_pulse_seq #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  parameter int CW     = CNT_W + $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_req,
  input  logic              glb_req,
  input  logic [NUM_CH-1:0] seq_mask,
  input  logic [CNT_W-1:0]  stretch_len,
  input  logic [CNT_W-1:0]  stagger_len,
  output logic [NUM_CH-1:0] rst_out_n,
  output logic              busy,
  output logic              seq_done
);

  typedef enum logic {IDLE, SEQ} state_t;

  state_t            state;
  logic [CW-1:0]     cnt      [NUM_CH];
  logic [CW-1:0]     cnt_next [NUM_CH];
  logic [CW-1:0]     rank     [NUM_CH];
  logic [CNT_W-1:0]  len_eff;
  logic              glb_load;
  logic [NUM_CH-1:0] mask_eff;
  logic [NUM_CH-1:0] active_next;

  assign len_eff  = (stretch_len == '0) ? CNT_W'(1) : stretch_len;
  // Block reset behaves as a global load with every channel enabled.
  assign glb_load = rst | glb_req;
  assign mask_eff = rst ? '1 : seq_mask;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      // Rank = number of enabled channels below this one (prefix popcount).
      if (gi == 0) begin : g_rank0
        assign rank[gi] = '0;
      end else begin : g_rankn
        assign rank[gi] = rank[gi-1] + CW'(mask_eff[gi-1]);
      end

      // Next count is the max of the saturating decrement and every load
      // candidate, so a request can only extend a running hold.
      always_comb begin
        logic [CW-1:0] dec;
        logic [CW-1:0] cand_ch;
        logic [CW-1:0] cand_glb;
        dec      = (cnt[gi] == '0) ? '0 : cnt[gi] - CW'(1);
        cand_ch  = ch_req[gi] ? CW'(len_eff) : '0;
        cand_glb = (glb_load && mask_eff[gi])
                 ? CW'(len_eff) + rank[gi] * CW'(stagger_len) : '0;
        cnt_next[gi] = dec;
        if (cand_ch > cnt_next[gi])  cnt_next[gi] = cand_ch;
        if (cand_glb > cnt_next[gi]) cnt_next[gi] = cand_glb;
      end

      assign active_next[gi] = (cnt_next[gi] != '0);

      // No explicit reset branch: rst forces a full load through cnt_next.
      always_ff @(posedge clk) begin
        cnt[gi] <= cnt_next[gi];
      end
    end
  endgenerate

  // Outputs follow the next-state counters so rst_out_n changes on the same
  // edge as the load that causes it; seq_done lines up with the last release.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SEQ;
      rst_out_n <= '0;
      busy      <= 1'b1;
      seq_done  <= 1'b0;
    end else begin
      rst_out_n <= ~active_next;
      busy      <= |active_next;
      seq_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (glb_req) state <= SEQ;
        end
        SEQ: begin
          // A new glb_req restarts the sequence; the abandoned one gets no pulse.
          if (!glb_req && active_next == '0) begin
            state    <= IDLE;
            seq_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vi_rst_pulse_seq.sv
module tb_vi_rst_pulse_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] ch_req = '0;
  logic       glb_req = 1'b0;
  logic [3:0] seq_mask = '0;
  logic [7:0] stretch_len = 8'd10;
  logic [7:0] stagger_len = 8'd5;
  logic [3:0] rst_out_n;
  logic       busy;
  logic       seq_done;

  int checks = 0;
  int errors = 0;

  // Reference model: absolute edge at which each channel is released.
  int         e = 0;
  int         rel [4] = '{0, 0, 0, 0};
  bit         in_seq = 1'b0;
  logic [3:0] exp_n;
  logic       exp_busy;
  logic       exp_done;

  vi_rst_pulse_seq #(.NUM_CH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .ch_req(ch_req), .glb_req(glb_req),
    .seq_mask(seq_mask), .stretch_len(stretch_len), .stagger_len(stagger_len),
    .rst_out_n(rst_out_n), .busy(busy), .seq_done(seq_done)
  );

  always #5 clk = ~clk;

  // Advance one clock edge and update the model from the inputs sampled there.
  task automatic tick();
    int l;
    int r;
    int cand;
    bit all_free;
    @(posedge clk);
    e++;
    l = (stretch_len == 0) ? 1 : int'(stretch_len);
    r = 0;
    for (int k = 0; k < 4; k++) begin
      cand = 0;
      if (ch_req[k]) cand = l;
      if (rst || (glb_req && seq_mask[k])) begin
        if (l + r * int'(stagger_len) > cand) cand = l + r * int'(stagger_len);
        r++;
      end
      if (e + cand > rel[k]) rel[k] = e + cand;
    end
    all_free = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_n[k] = (e >= rel[k]);
      if (!exp_n[k]) all_free = 1'b0;
    end
    exp_busy = !all_free;
    exp_done = 1'b0;
    if (rst || glb_req) in_seq = 1'b1;
    else if (in_seq && all_free) begin
      in_seq   = 1'b0;
      exp_done = 1'b1;
    end
    #1;
  endtask

  task automatic test_power_on(input string name);
    int base;
    int rise [4];
    int done_at;
    int busy_fall;
    rst = 1'b1; ch_req = '0; glb_req = 1'b0;
    stretch_len = 8'd10; stagger_len = 8'd5; seq_mask = 4'($urandom);
    repeat (3) begin
      tick();
      if (rst_out_n !== 4'b0000 || busy !== 1'b1 || seq_done !== 1'b0) begin
        errors++;
        $display("FAIL %s_reset_state got n=%b busy=%b done=%b want n=0000 busy=1 done=0",
                 name, rst_out_n, busy, seq_done);
      end
      checks++;
    end
    rst = 1'b0;
    base = e;
    rise = '{-1, -1, -1, -1};
    done_at = -1; busy_fall = -1;
    repeat (35) begin
      tick();
      if (rst_out_n !== exp_n || busy !== exp_busy || seq_done !== exp_done) begin
        errors++;
        $display("FAIL %s_model e=%0d got n=%b busy=%b done=%b want n=%b busy=%b done=%b",
                 name, e, rst_out_n, busy, seq_done, exp_n, exp_busy, exp_done);
      end
      checks++;
      for (int k = 0; k < 4; k++)
        if (rise[k] < 0 && rst_out_n[k] === 1'b1) rise[k] = e - base;
      if (done_at < 0 && seq_done === 1'b1) done_at = e - base;
      if (busy_fall < 0 && busy === 1'b0) busy_fall = e - base;
    end
    for (int k = 0; k < 4; k++) begin
      if (rise[k] != 10 + 5 * k) begin
        errors++;
        $display("FAIL %s_rise_ch%0d got %0d want %0d", name, k, rise[k], 10 + 5 * k);
      end
      checks++;
    end
    if (done_at != 25 || busy_fall != 25) begin
      errors++;
      $display("FAIL %s_done_busy got done@%0d busy_fall@%0d want 25/25", name, done_at, busy_fall);
    end
    checks++;
    $display("%s: releases %0d/%0d/%0d/%0d seq_done@%0d", name, rise[0], rise[1], rise[2], rise[3], done_at);
  endtask

  task automatic test_single_pulse();
    int low2 = 0, low_other = 0, dones = 0;
    stretch_len = 8'd0; ch_req = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      tick();
      ch_req = '0;
      if (rst_out_n !== exp_n || busy !== exp_busy || seq_done !== exp_done) begin
        errors++;
        $display("FAIL single_model e=%0d got n=%b busy=%b done=%b want n=%b busy=%b done=%b",
                 e, rst_out_n, busy, seq_done, exp_n, exp_busy, exp_done);
      end
      checks++;
      if (rst_out_n[2] === 1'b0) low2++;
      if (rst_out_n[0] !== 1'b1 || rst_out_n[1] !== 1'b1 || rst_out_n[3] !== 1'b1) low_other++;
      if (seq_done !== 1'b0) dones++;
    end
    if (low2 != 1 || low_other != 0 || dones != 0) begin
      errors++;
      $display("FAIL single_pulse got low=%0d other=%0d done=%0d want 1/0/0", low2, low_other, dones);
    end
    checks++;
    $display("single_pulse: ch2 low %0d cycle(s)", low2);
  endtask

  task automatic test_retrigger();
    int low1 = 0;
    for (int i = 0; i <= 40; i++) begin
      ch_req = '0;
      if (i == 0)  begin ch_req = 4'b0010; stretch_len = 8'd20; end
      if (i == 15) begin ch_req = 4'b0010; stretch_len = 8'd4;  end
      if (i == 18) begin ch_req = 4'b0010; stretch_len = 8'd10; end
      tick();
      if (rst_out_n !== exp_n || busy !== exp_busy || seq_done !== exp_done) begin
        errors++;
        $display("FAIL retrig_model e=%0d got n=%b busy=%b done=%b want n=%b busy=%b done=%b",
                 e, rst_out_n, busy, seq_done, exp_n, exp_busy, exp_done);
      end
      checks++;
      if (rst_out_n[1] === 1'b0) low1++;
    end
    ch_req = '0;
    if (low1 != 28) begin
      errors++;
      $display("FAIL retrigger_release got %0d want 28", low1);
    end
    checks++;
    $display("retrigger: ch1 low %0d cycles", low1);
  endtask

  task automatic test_masked();
    int low [4] = '{0, 0, 0, 0};
    int done_at = -1;
    int t0;
    seq_mask = 4'b1010; stretch_len = 8'd8; stagger_len = 8'd3; glb_req = 1'b1;
    tick();
    t0 = e;
    glb_req = 1'b0;
    for (int k = 0; k < 4; k++) if (rst_out_n[k] === 1'b0) low[k]++;
    repeat (20) begin
      tick();
      if (rst_out_n !== exp_n || busy !== exp_busy || seq_done !== exp_done) begin
        errors++;
        $display("FAIL masked_model e=%0d got n=%b busy=%b done=%b want n=%b busy=%b done=%b",
                 e, rst_out_n, busy, seq_done, exp_n, exp_busy, exp_done);
      end
      checks++;
      for (int k = 0; k < 4; k++) if (rst_out_n[k] === 1'b0) low[k]++;
      if (done_at < 0 && seq_done === 1'b1) done_at = e - t0;
    end
    if (low[0] != 0 || low[1] != 8 || low[2] != 0 || low[3] != 11 || done_at != 11) begin
      errors++;
      $display("FAIL masked_seq got low=%0d/%0d/%0d/%0d done@%0d want 0/8/0/11 done@11",
               low[0], low[1], low[2], low[3], done_at);
    end
    checks++;
    $display("masked: ch1 low %0d ch3 low %0d seq_done@%0d", low[1], low[3], done_at);
  endtask

  task automatic test_overlap();
    int dones = 0, done_at = -1, t0 = 0;
    seq_mask = 4'b1111; stretch_len = 8'd6; stagger_len = 8'd2;
    for (int i = 0; i <= 30; i++) begin
      glb_req = (i == 0 || i == 5);
      tick();
      if (i == 0) t0 = e;
      if (rst_out_n !== exp_n || busy !== exp_busy || seq_done !== exp_done) begin
        errors++;
        $display("FAIL overlap_model e=%0d got n=%b busy=%b done=%b want n=%b busy=%b done=%b",
                 e, rst_out_n, busy, seq_done, exp_n, exp_busy, exp_done);
      end
      checks++;
      if (seq_done === 1'b1) begin dones++; done_at = e - t0; end
    end
    glb_req = 1'b0;
    if (dones != 1 || done_at != 17) begin
      errors++;
      $display("FAIL overlap_done got count=%0d at=%0d want 1 at 17", dones, done_at);
    end
    checks++;
    $display("overlap: %0d seq_done at %0d", dones, done_at);
  endtask

  task automatic test_rst_mid();
    seq_mask = 4'b1111; stretch_len = 8'd10; stagger_len = 8'd5;
    for (int i = 0; i < 6; i++) begin
      glb_req = (i == 0);
      tick();
      if (rst_out_n !== exp_n || busy !== exp_busy || seq_done !== exp_done) begin
        errors++;
        $display("FAIL rstmid_model e=%0d got n=%b busy=%b done=%b want n=%b busy=%b done=%b",
                 e, rst_out_n, busy, seq_done, exp_n, exp_busy, exp_done);
      end
      checks++;
    end
    glb_req = 1'b0;
    test_power_on("rst_mid");
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      rst         = ($urandom_range(0, 299) == 0);
      glb_req     = ($urandom_range(0, 39) == 0);
      ch_req      = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
      seq_mask    = 4'($urandom);
      stretch_len = 8'($urandom_range(0, 20));
      stagger_len = 8'($urandom_range(0, 6));
      tick();
      if (rst_out_n !== exp_n || busy !== exp_busy || seq_done !== exp_done) begin
        errors++;
        $display("FAIL random_model e=%0d got n=%b busy=%b done=%b want n=%b busy=%b done=%b",
                 e, rst_out_n, busy, seq_done, exp_n, exp_busy, exp_done);
      end
      checks++;
    end
    rst = 1'b0; glb_req = 1'b0; ch_req = '0;
    $display("random: 1500 cycles compared");
  endtask

  initial begin
    test_power_on("power_on");
    test_single_pulse();
    test_retrigger();
    test_masked();
    test_overlap();
    test_rst_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vi_rst_pulse_seq.md
# vi_rst_pulse_seq

Parametrised multi-channel reset stretcher and sequencer in a single clock domain. Converts self-clearing control-register reset bits into stretched, active-low reset pulses per channel. A global request, or block reset, releases all enabled channels in a fixed staggered order. Sits between the control-register file and the datapath sub-blocks whose resets it drives.

## Interface
Parameters:
- NUM_CH, 4, number of reset output channels (1..16)
- CNT_W, 8, width of stretch_len and stagger_len
- CW, CNT_W+$clog2(NUM_CH), internal per-channel counter width (derived; not overridden)

Ports:
- clk  in  1  block clock
- rst  in  1  synchronous, active-high reset
- ch_req  in  NUM_CH  per-channel reset request, active-high, pulse or level
- glb_req  in  1  global sequenced reset request, active-high
- seq_mask  in  NUM_CH  1 = channel takes part in global sequence
- stretch_len  in  CNT_W  reset hold length in cycles; 0 treated as 1
- stagger_len  in  CNT_W  extra delay between successive channel releases in a global sequence
- rst_out_n  out  NUM_CH  stretched active-low reset per channel
- busy  out  1  any channel currently held in reset
- seq_done  out  1  one-cycle pulse when a global sequence completes

## Operation
- Each channel k has a down-counter cnt[k] of CW bits. rst_out_n[k] is registered, and is 0 exactly while the next-state cnt[k] != 0.
- L = (stretch_len == 0) ? 1 : stretch_len. S = stagger_len. Both are sampled only on the cycle a load occurs; later changes do not affect a running count.
- Per-channel load: if ch_req[k] = 1, then cand = L.
- Global load: if glb_req = 1 and seq_mask[k] = 1, then cand = L + r*S. r is the rank of k among the set bits of seq_mask, counting from bit 0 upward; the lowest enabled channel has r = 0.
- Load rule: cnt[k] <= max(cnt[k]-1 saturated at 0, all cands for k). A request never shortens a running hold. A repeated or level request re-extends the hold each cycle it is high, which is the retrigger behaviour.
- With no request, cnt[k] decrements to 0 and holds there.
- Arithmetic: L + r*S <= NUM_CH*(2^CNT_W - 1), so it fits in CW bits with no overflow.
- FSM, two states:
  - IDLE -> SEQ on a global load (glb_req, or reset release).
  - SEQ -> IDLE when every cnt is 0; seq_done = 1 on that cycle.
  - glb_req while in SEQ reloads per the max rule and stays in SEQ. No seq_done is issued for the abandoned sequence.
- A global load with seq_mask = 0 loads nothing. The FSM goes to SEQ and returns to IDLE on the next cycle with a seq_done pulse.
- busy = OR of (cnt[k] != 0), registered alongside rst_out_n.
- ch_req activity has no effect on the FSM. It can delay seq_done while in SEQ, because seq_done waits for all counters.

## Timing
- While rst = 1: rst_out_n = 0 (all bits), busy = 1, seq_done = 0, FSM = SEQ.
- Counters are loaded as if glb_req = 1 with seq_mask treated as all-ones, using the current stretch_len and stagger_len.
- First cycle after rst falls: counters start decrementing. Channel r releases L + r*S cycles after rst deasserts.
- Request sampled at clock edge t: rst_out_n[k] is 0 from edge t+1 and returns to 1 at edge t+1+cand. The low time is exactly cand cycles.
- seq_done is registered. It is high for one cycle, coincident with the cycle the last rst_out_n bit goes to 1.
- Asserting rst mid-sequence aborts the sequence with no seq_done, then restarts the power-on sequence.
- No combinational path from any input to any output.

## Test plan
- Power-on: stretch_len=10, stagger_len=5, NUM_CH=4, rst held 3 cycles then dropped -> rst_out_n[0..3] rise 10/15/20/25 cycles after rst falls. seq_done pulses with ch3's rise. busy falls on that same cycle.
- Single pulse: ch_req[2] one cycle, stretch_len=0 -> rst_out_n[2] low exactly 1 cycle. Other channels are unaffected and seq_done stays 0.
- Retrigger/no-shorten: ch_req[1] with L=20, then ch_req[1] again 15 cycles later with L=4 -> the release is unchanged at cycle 20. A third request at cycle 18 with L=10 -> release moves to cycle 28.
- Masked sequence: seq_mask=4'b1010, L=8, S=3, glb_req pulse -> ch1 low 8 cycles and ch3 low 11 cycles. ch0 and ch2 stay 1. seq_done pulses at cycle 11.
- Overlap: glb_req at t, and again at t+5 while in SEQ -> counts extend per the max rule. Exactly one seq_done is issued, after the second sequence completes.
- Reset mid-sequence: rst asserted at t+6 of a global sequence -> all outputs go 0 at t+7 with no seq_done. The full power-on timing repeats after rst falls.
